cam_cfg_sequencer: RTL and testbench

//  Parametrised camera register-init sequencer. Walks a selectable init table held in an

---
 rtl/cam_cfg_pkg.sv | 46 ++++
 rtl/cam_cfg_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_cfg_pkg.sv
// ----------------------------------------------------------------------------
// cam_cfg_pkg
//  Shared definitions for the camera register-init sequencer.
//  Contents:
//    op_e        init-table opcodes (WRITE, DELAY, END, reserved)
//    state_e     sequencer state encoding
//    OP_W        width of the opcode field at the top of every table entry
//    decode_next maps a fetched opcode to the state that handles it
// ----------------------------------------------------------------------------
package cam_cfg_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_WR  = 2'b00,   // write data to addr
      OP_DLY = 2'b01,   // wait data * DELAY_UNIT clock cycles
      OP_END = 2'b10,   // end of table
      OP_RSV = 2'b11    // reserved; treated as a table error
   } op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_DELAY,
      S_NEXT,
      S_DONE,
      S_ERROR
   } state_e;

   // A zero-length delay carries no wait at all, so it goes straight on to
   // the next entry instead of spending a cycle in the delay state.
   function automatic state_e decode_next(input op_e op, input logic zero_delay);
      state_e nxt;
      case (op)
         OP_WR:   nxt = S_ISSUE;
         OP_DLY:  nxt = zero_delay ? S_NEXT : S_DELAY;
         OP_END:  nxt = S_DONE;
         default: nxt = S_ERROR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/cam_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// cam_cfg_sequencer
//  Walks one profile of the camera init table held in an external ROM and
//  turns each entry into an SCCB register write, a timed delay, or the end of
//  the sequence. NACKed writes are re-issued up to MAX_RETRY times.
//
//  Ports
//    clk, rst     clock; synchronous active-high reset
//    start        1-cycle pulse, begins a sequence when not busy
//    table_sel    profile number, captured when start is accepted
//    rom_addr     {profile, index} to the ROM (registered read, 1-cycle latency)
//    rom_data     {op[1:0], addr, data} entry returned by the ROM
//    wr_valid     write request to the SCCB master
//    wr_ready     master accepts the request (valid & ready)
//    wr_addr      register address, stable while wr_valid
//    wr_data      register data, stable while wr_valid
//    wr_done      1-cycle pulse when the bus transaction has finished
//    wr_nack      qualifies wr_done: the slave did not acknowledge
//    busy         a sequence is in progress
//    done         sticky: last sequence completed
//    error        sticky: retries exhausted or reserved opcode
//    err_idx      index of the entry that caused error
// ----------------------------------------------------------------------------
module cam_cfg_sequencer
   import cam_cfg_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int IDX_W      = 8,
   parameter int TSEL_W     = 1,
   parameter int DELAY_UNIT = 50000,
   parameter int MAX_RETRY  = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [TSEL_W-1:0]             table_sel,
   output logic [TSEL_W+IDX_W-1:0]       rom_addr,
   input  logic [OP_W+ADDR_W+DATA_W-1:0] rom_data,
   output logic                          wr_valid,
   input  logic                          wr_ready,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [DATA_W-1:0]             wr_data,
   input  logic                          wr_done,
   input  logic                          wr_nack,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [IDX_W-1:0]              err_idx
);

   // The delay counter must hold (2**DATA_W - 1) * DELAY_UNIT - 1.
   localparam int CNT_W   = DATA_W + $clog2(DELAY_UNIT);
   // One spare bit so that MAX_RETRY = 0 still yields a legal vector.
   localparam int RETRY_W = $clog2(MAX_RETRY + 2);

   localparam logic [CNT_W-1:0]   UNIT      = CNT_W'(DELAY_UNIT);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [IDX_W-1:0]   LAST_IDX  = '1;

   state_e               state;
   state_e               state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [TSEL_W-1:0]    tsel;
   logic [RETRY_W-1:0]   retry;
   logic [CNT_W-1:0]     dly_cnt;

   op_e                  ent_op;
   logic [ADDR_W-1:0]    ent_addr;
   logic [DATA_W-1:0]    ent_data;
   logic                 start_ok;
   logic                 can_retry;

   assign ent_op   = op_e'(rom_data[ADDR_W+DATA_W +: OP_W]);
   assign ent_addr = rom_data[DATA_W +: ADDR_W];
   assign ent_data = rom_data[DATA_W-1:0];

   assign rom_addr  = {tsel, idx};
   assign start_ok  = start && !busy;
   assign can_retry = (retry < RETRY_MAX);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      wr_valid  = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH:  state_nxt = S_DECODE;   // ROM answers one cycle later
         S_DECODE: state_nxt = decode_next(ent_op, ent_data == '0);
         S_ISSUE: begin
            wr_valid = 1'b1;
            if (wr_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wr_done) begin
               if (!wr_nack)       state_nxt = S_NEXT;
               else if (can_retry) state_nxt = S_ISSUE;
               else                state_nxt = S_ERROR;
            end
         end
         S_DELAY: if (dly_cnt == '0) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
         // Status is already final here, so a new start is taken at once.
         S_DONE, S_ERROR: begin
            busy      = 1'b0;
            state_nxt = start ? S_FETCH : S_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: index, retry, delay counter, write fields, status
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         tsel    <= '0;
         retry   <= '0;
         dly_cnt <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
         error   <= 1'b0;
         err_idx <= '0;
      end else begin
         if (start_ok) begin
            idx   <= '0;
            tsel  <= table_sel;
            retry <= '0;
            done  <= 1'b0;
            error <= 1'b0;
         end

         if (state == S_DECODE) begin
            if (ent_op == OP_WR) begin
               wr_addr <= ent_addr;
               wr_data <= ent_data;
            end
            // Counting down to zero inclusive gives exactly data*UNIT cycles.
            if (ent_op == OP_DLY) dly_cnt <= CNT_W'(ent_data) * UNIT - CNT_W'(1);
         end

         if (state == S_DELAY && dly_cnt != '0) dly_cnt <= dly_cnt - CNT_W'(1);

         if (state == S_WAIT && wr_done && wr_nack && can_retry)
            retry <= retry + RETRY_W'(1);

         if (state == S_NEXT) begin
            retry <= '0;
            // The last index ends the table instead of wrapping to entry 0.
            if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
         end

         if (state_nxt == S_DONE) done <= 1'b1;
         if (state_nxt == S_ERROR) begin
            error   <= 1'b1;
            err_idx <= idx;
         end
      end
   end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cam_cfg_sequencer
//  Self-checking bench for cam_cfg_sequencer. A behavioural ROM and SCCB
//  master surround the DUT; a reference model walks each table entry by entry
//  and predicts the write list, the cycle gaps before each write, the NACK
//  responses to give, and the final done/error status.
// ----------------------------------------------------------------------------
module tb_cam_cfg_sequencer;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;
   localparam int IDX_W      = 3;
   localparam int TSEL_W     = 1;
   localparam int DELAY_UNIT = 4;
   localparam int MAX_RETRY  = 3;
   localparam int DEPTH      = 2**IDX_W;
   localparam int ENT_W      = 2 + ADDR_W + DATA_W;
   localparam int BUDGET     = 4000;

   localparam logic [1:0] C_WR  = 2'b00;
   localparam logic [1:0] C_DLY = 2'b01;
   localparam logic [1:0] C_END = 2'b10;
   localparam logic [1:0] C_RSV = 2'b11;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [TSEL_W-1:0]       table_sel;
   logic [TSEL_W+IDX_W-1:0] rom_addr;
   logic [ENT_W-1:0]        rom_data = '0;
   logic                    wr_valid;
   logic                    wr_ready;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic                    wr_done;
   logic                    wr_nack;
   logic                    busy;
   logic                    done;
   logic                    error;
   logic [IDX_W-1:0]        err_idx;

   logic m_ready = 1'b0, m_done = 1'b0, m_nack = 1'b0;
   logic f_done = 1'b0, hold_ready = 1'b0;

   assign wr_ready = m_ready;
   assign wr_done  = m_done | f_done;
   assign wr_nack  = m_nack;

   cam_cfg_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .TSEL_W(TSEL_W),
      .DELAY_UNIT(DELAY_UNIT), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .table_sel(table_sel),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_done(wr_done), .wr_nack(wr_nack),
      .busy(busy), .done(done), .error(error), .err_idx(err_idx)
   );

   initial forever #5 clk = ~clk;

   // ---------------- environment state ----------------
   logic [ENT_W-1:0] rom_mem [2*DEPTH];
   int               nack_cnt [DEPTH];

   logic [15:0] exp_w[$];
   int          exp_gap[$];
   bit          nack_q[$];
   logic        exp_done, exp_err;
   logic [31:0] exp_eidx;

   logic [15:0] obs_w[$];
   int          obs_gap[$];
   int          stab_err = 0, tsel_err = 0;
   int          cyc = 0, ref_cyc = 0;
   logic        cur_tsel = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [ENT_W-1:0] ent(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] d);
      return {op, a, d};
   endfunction

   function automatic logic [31:0] outs();
      return {5'b0, rom_addr, wr_valid, wr_addr, wr_data, busy, done, error, err_idx};
   endfunction

   // ---------------- ROM: registered read, one cycle latency ----------------
   initial begin
      logic [TSEL_W+IDX_W-1:0] a;
      forever begin
         @(negedge clk);
         a = rom_addr;
         @(posedge clk);
         #1 rom_data = rom_mem[a];
      end
   end

   // ---------------- SCCB master: random backpressure and done latency -------
   initial begin
      forever begin
         @(posedge clk); #1;
         if (wr_valid && !hold_ready && !rst) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            m_done = 1'b1;
            m_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
            @(posedge clk); #1;
            m_done = 1'b0;
            m_nack = 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      logic        prev_valid;
      logic [15:0] prev_ad;
      prev_valid = 1'b0;
      prev_ad    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (start && !busy) ref_cyc = cyc;
            if (m_done)         ref_cyc = cyc;
            if (wr_valid && !prev_valid) obs_gap.push_back(cyc - ref_cyc);
            if (wr_valid && prev_valid && {wr_addr, wr_data} != prev_ad) stab_err++;
            if (wr_valid && wr_ready) obs_w.push_back({wr_addr, wr_data});
            if (busy && rom_addr[IDX_W +: TSEL_W] != cur_tsel) tsel_err++;
            prev_valid = wr_valid;
            prev_ad    = {wr_addr, wr_data};
         end
      end
   end

   // ---------------- reference model ----------------
   // Gaps are counted from the reference event (accepted start, or wr_done of
   // the previous attempt) to the first cycle of wr_valid. Each entry visited
   // costs NEXT/FETCH/DECODE; a delay adds data*DELAY_UNIT cycles on top.
   task automatic build_model(input int tsel);
      int pend;
      exp_w.delete(); exp_gap.delete(); nack_q.delete();
      exp_done = 1'b0; exp_err = 1'b0; exp_eidx = '0;
      pend = 3;                              // FETCH, DECODE, then ISSUE
      for (int i = 0; i < DEPTH; i++) begin
         logic [ENT_W-1:0] e;
         int               n;
         e = rom_mem[tsel*DEPTH + i];
         case (e[17:16])
            C_WR: begin
               n = (nack_cnt[i] > MAX_RETRY) ? MAX_RETRY + 1 : nack_cnt[i] + 1;
               for (int k = 0; k < n; k++) begin
                  exp_w.push_back(e[15:0]);
                  exp_gap.push_back((k == 0) ? pend : 1);
                  nack_q.push_back(k < nack_cnt[i]);
               end
               if (nack_cnt[i] > MAX_RETRY) begin
                  exp_err  = 1'b1;
                  exp_eidx = 32'(i);
                  return;
               end
               pend = 4;                     // NEXT, FETCH, DECODE, then ISSUE
            end
            C_DLY: pend += 3 + int'(e[7:0]) * DELAY_UNIT;
            C_END: begin
               exp_done = 1'b1;
               return;
            end
            default: begin
               exp_err  = 1'b1;
               exp_eidx = 32'(i);
               return;
            end
         endcase
      end
      exp_done = 1'b1;                       // ran off the last entry
   endtask

   task automatic clear_profile(input int tsel);
      for (int i = 0; i < DEPTH; i++) begin
         rom_mem[tsel*DEPTH + i] = ent(C_RSV, 8'hEE, 8'hEE);
         nack_cnt[i] = 0;
      end
   endtask

   task automatic random_profile(input int tsel);
      for (int i = 0; i < DEPTH; i++) begin
         int         p;
         logic [7:0] a, d;
         p = $urandom_range(0, 99);
         a = 8'($urandom);
         d = 8'($urandom);
         if (p < 70)      rom_mem[tsel*DEPTH + i] = ent(C_WR, a, d);
         else if (p < 85) rom_mem[tsel*DEPTH + i] = ent(C_DLY, a, 8'($urandom_range(0, 3)));
         else if (p < 94) rom_mem[tsel*DEPTH + i] = ent(C_END, a, d);
         else             rom_mem[tsel*DEPTH + i] = ent(C_RSV, a, d);
         p = $urandom_range(0, 19);
         nack_cnt[i] = (p < 14) ? 0 : (p < 17) ? 1 : (p < 19) ? 3 : 4;
      end
   endtask

   // Called one time unit after a rising edge; returns at the same phase.
   task automatic run_seq(input string tag, input int tsel, input bit poke);
      int t;
      build_model(tsel);
      obs_w.delete(); obs_gap.delete();
      stab_err = 0;
      tsel_err = 0;
      cur_tsel  = tsel[0];
      table_sel = TSEL_W'(tsel);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      table_sel = ~table_sel;                // profile must already be latched
      check({tag, ".clr"}, 32'({busy, done, error}), 32'b100);
      t = 0;
      while (busy && t < BUDGET) begin
         if (poke && t == 6) start = 1'b1;   // must be ignored while busy
         @(posedge clk); #1;
         start = 1'b0;
         t++;
      end
      check({tag, ".bound"}, 32'(t < BUDGET), 32'd1);
      @(posedge clk); #1;
      check({tag, ".nwr"}, obs_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
         check($sformatf("%s.wr%0d", tag, i), 32'(obs_w[i]), 32'(exp_w[i]));
      check({tag, ".ngap"}, obs_gap.size(), exp_gap.size());
      for (int i = 0; i < exp_gap.size() && i < obs_gap.size(); i++)
         check($sformatf("%s.gap%0d", tag, i), obs_gap[i], exp_gap[i]);
      check({tag, ".done"}, 32'(done), 32'(exp_done));
      check({tag, ".error"}, 32'(error), 32'(exp_err));
      if (exp_err) check({tag, ".err_idx"}, 32'(err_idx), exp_eidx);
      check({tag, ".stable"}, stab_err, 0);
      check({tag, ".tsel"}, tsel_err, 0);
      check({tag, ".valid_off"}, 32'(wr_valid), 32'd0);
      check({tag, ".rsp_left"}, nack_q.size(), 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      rst = 1'b1;
      start = 1'b0;
      table_sel = '0;
      clear_profile(0);
      clear_profile(1);
      repeat (3) @(posedge clk);
      #1;
      check("reset.outs", outs(), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle.outs", outs(), 32'd0);

      // Two writes then END.
      clear_profile(0);
      rom_mem[0] = ent(C_WR, 8'h12, 8'h80);
      rom_mem[1] = ent(C_WR, 8'hFF, 8'h01);
      rom_mem[2] = ent(C_END, 8'h00, 8'h00);
      run_seq("two_wr", 0, 1'b0);

      // Delay 3 ticks (12 cycles) and delay 0 (no wait).
      clear_profile(0);
      rom_mem[0] = ent(C_WR, 8'h11, 8'h22);
      rom_mem[1] = ent(C_DLY, 8'h00, 8'd3);
      rom_mem[2] = ent(C_WR, 8'h33, 8'h44);
      rom_mem[3] = ent(C_DLY, 8'h00, 8'd0);
      rom_mem[4] = ent(C_WR, 8'h55, 8'h66);
      rom_mem[5] = ent(C_END, 8'h00, 8'h00);
      run_seq("delay", 0, 1'b0);

      // NACK twice on entry 5, then ACK.
      clear_profile(1);
      for (int i = 0; i < 7; i++) rom_mem[DEPTH + i] = ent(C_WR, 8'(i*16 + 1), 8'(i));
      rom_mem[DEPTH + 5] = ent(C_WR, 8'hAA, 8'hBB);
      rom_mem[DEPTH + 7] = ent(C_END, 8'h00, 8'h00);
      nack_cnt[5] = 2;
      run_seq("retry_ok", 1, 1'b1);

      // NACK four times on entry 5: retries exhausted.
      nack_cnt[5] = 4;
      run_seq("retry_err", 1, 1'b0);

      // A new start clears the error and completes.
      nack_cnt[5] = 0;
      run_seq("rerun", 1, 1'b0);

      // Full table without END: DEPTH writes, no wrap.
      clear_profile(0);
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = ent(C_WR, 8'(8'hC0 + i), 8'(8'h30 + i));
      run_seq("full", 0, 1'b0);

      // Randomized tables on both profiles.
      for (int r = 0; r < 14; r++) begin
         int ts;
         ts = $urandom_range(0, 1);
         random_profile(ts);
         run_seq($sformatf("rnd%0d", r), ts, r[0]);
      end

      // Reset while stalled in ISSUE on profile 1; stray wr_done is ignored.
      clear_profile(1);
      rom_mem[DEPTH + 0] = ent(C_WR, 8'h5A, 8'hA5);
      rom_mem[DEPTH + 1] = ent(C_END, 8'h00, 8'h00);
      hold_ready = 1'b1;
      cur_tsel   = 1'b1;
      table_sel  = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (!wr_valid && t < 20) begin @(posedge clk); #1; t++; end
      check("rst_issue.valid", 32'(wr_valid), 32'd1);
      check("rst_issue.rom_msb", 32'(rom_addr[IDX_W +: TSEL_W]), 32'd1);
      f_done = 1'b1;
      @(posedge clk); #1;
      f_done = 1'b0;
      @(posedge clk); #1;
      check("stray_done", 32'({wr_valid, busy, wr_addr}), 32'h35A);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_issue.outs", outs(), 32'd0);
      rst = 1'b0;
      hold_ready = 1'b0;
      @(posedge clk); #1;

      // Reset while in a long delay, with start coincident with reset.
      clear_profile(0);
      rom_mem[0] = ent(C_DLY, 8'h00, 8'd200);
      cur_tsel  = 1'b0;
      table_sel = 1'b0;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_delay.in_delay", 32'({busy, wr_valid}), 32'b10);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      check("rst_delay.outs", outs(), 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      check("rst_wins.outs", outs(), 32'd0);

      // Recovery after reset on profile 1.
      clear_profile(1);
      rom_mem[DEPTH + 0] = ent(C_WR, 8'h01, 8'h02);
      rom_mem[DEPTH + 1] = ent(C_DLY, 8'h00, 8'd1);
      rom_mem[DEPTH + 2] = ent(C_WR, 8'h03, 8'h04);
      rom_mem[DEPTH + 3] = ent(C_RSV, 8'h00, 8'h00);
      nack_cnt[2] = 1;
      run_seq("after_rst", 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
